// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for a word-addressed data memory.
// Handles byte/halfword lane selection, sign/zero extension and
// read-modify-write for sub-word stores. One request in flight at a time.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RMW_RD,
        S_WR,
        S_RMW_WR,
        S_ERR,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [1:0]        lane_q, lane_d;
    logic [15:0]       wdata_lo_q, wdata_lo_d;

    logic              misaligned;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] rd_shifted;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] lane_data;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] merged;

    // Lane extraction/extension for loads and lane merge for sub-word stores
    always_comb begin
        misaligned = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        shamt      = (size_q == 2'b01) ? {lane_q[1], 4'b0000} : {lane_q, 3'b000};
        rd_shifted = mem_rdata >> shamt;
        load_ext   = mem_rdata;
        lane_mask  = '0;
        lane_data  = '0;
        case (size_q)
            2'b00: begin
                load_ext  = {{24{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
                lane_mask = 32'h0000_00FF << shamt;
                lane_data = {24'h0, wdata_lo_q[7:0]} << shamt;
            end
            2'b01: begin
                load_ext  = {{16{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
                lane_mask = 32'h0000_FFFF << shamt;
                lane_data = {16'h0, wdata_lo_q} << shamt;
            end
            default: begin
                load_ext = mem_rdata;
            end
        endcase
        merged = (mem_rdata & ~lane_mask) | lane_data;
    end

    // Next-state and next-output computation for the request sequencer
    always_comb begin
        state_d      = state_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        size_d       = size_q;
        signed_d     = signed_q;
        lane_d       = lane_q;
        wdata_lo_d   = wdata_lo_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    size_d     = req_size;
                    signed_d   = req_signed;
                    lane_d     = req_addr[1:0];
                    wdata_lo_d = req_wdata[15:0];
                    if (misaligned) begin
                        state_d = S_ERR;
                    end else begin
                        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                        if (!req_we) begin
                            state_d = S_RD;
                        end else if (req_size == 2'b10) begin
                            state_d     = S_WR;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = req_wdata;
                        end else begin
                            state_d = S_RMW_RD;
                        end
                    end
                end
            end
            S_RD: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_ext;
                resp_err_d   = 1'b0;
            end
            S_RMW_RD: begin
                state_d     = S_RMW_WR;
                mem_we_d    = 1'b1;
                mem_wdata_d = merged;
            end
            S_WR, S_RMW_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
            end
            S_ERR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = '0;
                resp_err_d   = 1'b1;
            end
            S_RESP: begin
                state_d      = S_IDLE;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs; reset has priority over any request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            lane_q       <= '0;
            wdata_lo_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            lane_q       <= lane_d;
            wdata_lo_q   <= wdata_lo_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: 64-word memory with negedge writes,
// directed scenarios plus randomized traffic against a byte-lane model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] tb_mem  [0:63];
    logic [31:0] ref_mem [0:63];

    int tests = 0;
    int fails = 0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr[7:2]];

    always @(negedge clk) begin
        if (mem_we) tb_mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic set_word(input int idx, input logic [31:0] v);
        tb_mem[idx]  = v;
        ref_mem[idx] = v;
    endtask

    // Issue one request and check response, bus activity and memory contents.
    // Latency = number of posedges from the accept edge to the edge that
    // samples resp_valid high.
    task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input string name, output logic [31:0] got_rd);
        logic        mis;
        logic [31:0] old, nw, v, mask, exp_rd;
        int          idx, sh, exp_lat, exp_we, exp_err;
        int          k, we_cnt, wait_c;
        logic        done;
        logic [31:0] we_addr, we_data;
        logic        got_err;

        idx = int'(a[7:2]);
        old = ref_mem[idx];
        nw  = old;
        mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        exp_rd = 0; exp_err = 0; exp_we = 0; exp_lat = 2;
        if (mis) begin
            exp_err = 1;
        end else if (!we) begin
            if (sz == 2'd0) begin
                v = (old >> (8 * int'(a[1:0]))) & 32'hFF;
                if (sg && v[7]) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                v = (old >> (16 * int'(a[1]))) & 32'hFFFF;
                if (sg && v[15]) v = v | 32'hFFFF_0000;
            end else begin
                v = old;
            end
            exp_rd = v;
        end else begin
            exp_we = 1;
            if (sz == 2'd2) begin
                nw = wd;
            end else begin
                sh   = (sz == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
                mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
                nw   = (old & ~mask) | ((wd << sh) & mask);
                exp_lat = 3;
            end
        end

        wait_c = 0;
        while (!req_ready && wait_c < 10) begin
            @(posedge clk); #1;
            wait_c++;
        end
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_timeout: req_ready=%b required 1", name, req_ready);
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        // fields change after acceptance and must be ignored
        req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_signed = ~sg;
        req_addr = $urandom; req_wdata = $urandom;

        k = 1; we_cnt = 0; done = 1'b0; got_rd = 'x; got_err = 1'bx;
        we_addr = 0; we_data = 0;
        while (!done && k < 10) begin
            if (mem_we) begin
                we_cnt++; we_addr = mem_addr; we_data = mem_wdata;
            end
            if (resp_valid) begin
                done = 1'b1; got_rd = resp_rdata; got_err = resp_err;
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
        ref_mem[idx] = nw;

        tests++;
        if (!done || k != exp_lat) begin
            fails++;
            $display("FAIL %s latency: got %0d (done=%b) required %0d", name, k, done, exp_lat);
        end
        tests++;
        if (got_rd !== exp_rd) begin
            fails++;
            $display("FAIL %s rdata: got %h required %h", name, got_rd, exp_rd);
        end
        tests++;
        if (got_err !== exp_err[0]) begin
            fails++;
            $display("FAIL %s err: got %b required %0d", name, got_err, exp_err);
        end
        tests++;
        if (we_cnt != exp_we) begin
            fails++;
            $display("FAIL %s we_pulses: got %0d required %0d", name, we_cnt, exp_we);
        end
        if (exp_we == 1) begin
            tests++;
            if (we_addr !== {a[31:2], 2'b00} || we_data !== nw) begin
                fails++;
                $display("FAIL %s write: addr %h data %h required %h %h",
                         name, we_addr, we_data, {a[31:2], 2'b00}, nw);
            end
        end
        tests++;
        if (tb_mem[idx] !== ref_mem[idx]) begin
            fails++;
            $display("FAIL %s memword: got %h required %h", name, tb_mem[idx], ref_mem[idx]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if ({req_ready, mem_we, resp_valid, resp_err} !== 4'b1000 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: rdy=%b we=%b rv=%b err=%b addr=%h wd=%h rd=%h required 1 0 0 0 0 0 0",
                     req_ready, mem_we, resp_valid, resp_err, mem_addr, mem_wdata, resp_rdata);
        end
        // reset together with a valid request: request must be dropped
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
        req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (req_ready !== 1'b1 || mem_we !== 1'b0 || resp_valid !== 1'b0) begin
                fails++;
                $display("FAIL rst_vs_req: rdy=%b we=%b rv=%b required 1 0 0",
                         req_ready, mem_we, resp_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] r;
        set_word(1, 32'h0000_00F5);
        run_req(1'b0, 2'd0, 1'b1, 32'h04, 32'h0, "lb_signed", r);
        tests++;
        if (r !== 32'hFFFF_FFF5) begin
            fails++; $display("FAIL lb_signed_value: got %h required FFFFFFF5", r);
        end
        run_req(1'b0, 2'd0, 1'b0, 32'h04, 32'h0, "lb_unsigned", r);
        tests++;
        if (r !== 32'h0000_00F5) begin
            fails++; $display("FAIL lb_unsigned_value: got %h required 000000F5", r);
        end
        run_req(1'b0, 2'd2, 1'b1, 32'h04, 32'h0, "lw_ignores_signed", r);
    endtask

    task automatic test_subword_store();
        logic [31:0] r;
        set_word(2, 32'h1122_3344);
        run_req(1'b1, 2'd1, 1'b0, 32'h0A, 32'h1234_BEEF, "sh_0a", r);
        tests++;
        if (tb_mem[2] !== 32'hBEEF_3344) begin
            fails++; $display("FAIL sh_0a_word: got %h required BEEF3344", tb_mem[2]);
        end
        set_word(2, 32'h1122_3344);
        run_req(1'b1, 2'd0, 1'b0, 32'h09, 32'hFFFF_FFAA, "sb_09", r);
        tests++;
        if (tb_mem[2] !== 32'h1122_AA44) begin
            fails++; $display("FAIL sb_09_word: got %h required 1122AA44", tb_mem[2]);
        end
        run_req(1'b0, 2'd1, 1'b1, 32'h08, 32'h0, "lh_08_signed", r);
        tests++;
        if (r !== 32'hFFFF_AA44) begin
            fails++; $display("FAIL lh_08_value: got %h required FFFFAA44", r);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] r;
        run_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, "lw_misaligned", r);
        run_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, "size_reserved", r);
        run_req(1'b1, 2'd1, 1'b0, 32'h03, 32'hFFFF, "sh_misaligned", r);
    endtask

    task automatic test_back_to_back();
        int acc_cyc [3];
        int n, we_cnt, rv_cnt;
        logic acc;
        n = 0; we_cnt = 0; rv_cnt = 0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h00; req_wdata = 32'd1;
        for (int c = 0; c < 16; c++) begin
            acc = req_valid && req_ready;
            @(posedge clk); #1;
            if (acc && n < 3) begin
                acc_cyc[n] = c;
                n++;
                if (n < 3) begin
                    req_addr = 32'(4 * n); req_wdata = 32'(n + 1);
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (mem_we) we_cnt++;
            if (resp_valid) rv_cnt++;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) ref_mem[i] = 32'(i + 1);
        tests++;
        if (n != 3 || acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
            fails++;
            $display("FAIL b2b_accept_spacing: n=%0d cycles %0d %0d %0d required 3 accepts 3 apart",
                     n, acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
        tests++;
        if (we_cnt != 3 || rv_cnt != 3) begin
            fails++;
            $display("FAIL b2b_pulses: we=%0d rv=%0d required 3 3", we_cnt, rv_cnt);
        end
        tests++;
        if (tb_mem[0] !== 32'd1 || tb_mem[1] !== 32'd2 || tb_mem[2] !== 32'd3) begin
            fails++;
            $display("FAIL b2b_memory: got %h %h %h required 1 2 3", tb_mem[0], tb_mem[1], tb_mem[2]);
        end
    endtask

    task automatic test_reset_mid();
        int bad_we, bad_rv;
        bad_we = 0; bad_rv = 0;
        set_word(5, 32'hCAFE_F00D);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h15; req_wdata = 32'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        // now in the read half of the read-modify-write
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL rstmid_ready: got %b required 1", req_ready);
        end
        for (int i = 0; i < 5; i++) begin
            if (mem_we) bad_we++;
            if (resp_valid) bad_rv++;
            @(posedge clk); #1;
        end
        tests++;
        if (bad_we != 0 || bad_rv != 0) begin
            fails++; $display("FAIL rstmid_activity: we=%0d rv=%0d required 0 0", bad_we, bad_rv);
        end
        tests++;
        if (tb_mem[5] !== 32'hCAFE_F00D) begin
            fails++; $display("FAIL rstmid_word: got %h required CAFEF00D", tb_mem[5]);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 150; i++) begin
            run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                    $urandom, "random", r);
        end
        tests++;
        begin
            int diff = 0;
            for (int i = 0; i < 64; i++) if (tb_mem[i] !== ref_mem[i]) diff++;
            if (diff != 0) begin
                fails++; $display("FAIL random_memory: %0d words differ, required 0", diff);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) set_word(i, $urandom);
        test_reset();
        test_load_ext();
        test_subword_store();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
